superalu_arbiter: RTL and testbench

//  Shares the single SHARE_SUPERALU instance (multiply/divide/sqrt-pow) between two requesters:

---
 rtl/superalu_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_superalu_arbiter.sv | 503 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/superalu_arbiter.sv
// superalu_arbiter: shares one SHARE_SUPERALU between the CPU and the analog sequencer.
// Optional watchdog (err, TMO_CYC) compiled in with SUPERALU_TIMEOUT_EN.
module superalu_arbiter #(
  parameter int DW = 13
`ifdef SUPERALU_TIMEOUT_EN
  ,
  parameter int TMO_CYC = 255
`endif
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          req0,
  input  logic          req1,
  input  logic [DW-1:0] x0,
  input  logic [DW-1:0] x1,
  input  logic [DW-1:0] y0,
  input  logic [DW-1:0] y1,
  input  logic [2:0]    typ0,
  input  logic [2:0]    typ1,
  input  logic [1:0]    mod0,
  input  logic [1:0]    mod1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rslt_f,
  output logic [DW-1:0] rslt_p,
  output logic          busy,
  output logic          err,
  output logic [DW-1:0] X_IN,
  output logic [DW-1:0] Y_IN,
  output logic [2:0]    alu_type,
  output logic [1:0]    mode_type,
  output logic          alu_start,
  input  logic [DW-1:0] FOUT,
  input  logic [DW-1:0] POUT,
  input  logic          alu_is_done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_CAPT = 2'd2;
  localparam logic [1:0] S_REL  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          gnt_q, gnt_d;
  logic          rr_q, rr_d;
  logic [1:0]    done_q, done_d;
  logic [DW-1:0] x_q, x_d;
  logic [DW-1:0] y_q, y_d;
  logic [2:0]    typ_q, typ_d;
  logic [1:0]    mod_q, mod_d;
  logic          start_q, start_d;
  logic          arm_q, arm_d;
  logic [DW-1:0] rf_q, rf_d;
  logic [DW-1:0] rp_q, rp_d;

`ifdef SUPERALU_TIMEOUT_EN
  localparam logic [7:0] TMO_LIM = 8'(TMO_CYC - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  logic       pick;
  logic [2:0] typ_s;
  logic       legal;
  logic       req_g;

  always_comb begin
    pick  = (req0 & req1) ? rr_q : req1;
    typ_s = pick ? typ1 : typ0;
    legal = (typ_s == 3'b100) | (typ_s == 3'b010) | (typ_s == 3'b001);
    req_g = gnt_q ? req1 : req0;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rr_d    = rr_q;
    done_d  = done_q;
    x_d     = x_q;
    y_d     = y_q;
    typ_d   = typ_q;
    mod_d   = mod_q;
    start_d = start_q;
    arm_d   = arm_q;
    rf_d    = rf_q;
    rp_d    = rp_q;
`ifdef SUPERALU_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          gnt_d   = pick;
          x_d     = pick ? x1 : x0;
          y_d     = pick ? y1 : y0;
          typ_d   = typ_s;
          mod_d   = pick ? mod1 : mod0;
          start_d = legal;
          arm_d   = 1'b0;
`ifdef SUPERALU_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (legal) begin
            state_d = S_RUN;
          end else begin
            rf_d    = '0;
            rp_d    = '0;
            state_d = S_CAPT;
          end
        end
      end
      S_RUN: begin
        // a done level left over from before start is ignored until it drops
        if (!alu_is_done) arm_d = 1'b1;
        if (alu_is_done && arm_q) begin
          rf_d    = FOUT;
          rp_d    = POUT;
          start_d = 1'b0;
          state_d = S_CAPT;
        end
`ifdef SUPERALU_TIMEOUT_EN
        else if (cnt_q == TMO_LIM) begin
          err_d   = 1'b1;
          rf_d    = '1;
          rp_d    = '1;
          start_d = 1'b0;
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_CAPT: begin
        done_d  = gnt_q ? 2'b10 : 2'b01;
        rr_d    = ~gnt_q;
        state_d = S_REL;
      end
      S_REL: begin
        if (!req_g && !alu_is_done) begin
          done_d  = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      gnt_q   <= 1'b0;
      rr_q    <= 1'b0;
      done_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      typ_q   <= '0;
      mod_q   <= '0;
      start_q <= 1'b0;
      arm_q   <= 1'b0;
      rf_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      typ_q   <= typ_d;
      mod_q   <= mod_d;
      start_q <= start_d;
      arm_q   <= arm_d;
      rf_q    <= rf_d;
      rp_q    <= rp_d;
    end
  end

`ifdef SUPERALU_TIMEOUT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign done0     = done_q[0];
  assign done1     = done_q[1];
  assign rslt_f    = rf_q;
  assign rslt_p    = rp_q;
  assign busy      = (state_q != S_IDLE);
  assign X_IN      = x_q;
  assign Y_IN      = y_q;
  assign alu_type  = typ_q;
  assign mode_type = mod_q;
  assign alu_start = start_q;

endmodule

// File: tb/tb_superalu_arbiter.sv
// tb_superalu_arbiter: vector table, directed corner sequences and a
// randomized two-requester run against a behavioural ALU and result model.
module tb_superalu_arbiter;

  localparam int DW = 13;

  logic          clk;
  logic          rst_n;
  logic [1:0]    req;
  logic [DW-1:0] x [2];
  logic [DW-1:0] y [2];
  logic [2:0]    typ [2];
  logic [1:0]    mod [2];
  logic          done0, done1;
  logic [1:0]    done;
  logic [DW-1:0] rslt_f, rslt_p;
  logic          busy, err;
  logic [DW-1:0] X_IN, Y_IN;
  logic [2:0]    alu_type;
  logic [1:0]    mode_type;
  logic          alu_start;
  logic [DW-1:0] FOUT, POUT;
  logic          alu_is_done;
  logic          m_done;
  logic          stale;
  logic          alu_hang;
  int            alu_lat;
  int            acnt;

  int checks = 0;
  int errors = 0;

  assign done        = {done1, done0};
  assign alu_is_done = m_done | stale;

  superalu_arbiter #(
    .DW(DW)
`ifdef SUPERALU_TIMEOUT_EN
    ,
    .TMO_CYC(16)
`endif
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .req0(req[0]),
    .req1(req[1]),
    .x0(x[0]),
    .x1(x[1]),
    .y0(y[0]),
    .y1(y[1]),
    .typ0(typ[0]),
    .typ1(typ[1]),
    .mod0(mod[0]),
    .mod1(mod[1]),
    .done0(done0),
    .done1(done1),
    .rslt_f(rslt_f),
    .rslt_p(rslt_p),
    .busy(busy),
    .err(err),
    .X_IN(X_IN),
    .Y_IN(Y_IN),
    .alu_type(alu_type),
    .mode_type(mode_type),
    .alu_start(alu_start),
    .FOUT(FOUT),
    .POUT(POUT),
    .alu_is_done(alu_is_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {POUT, FOUT}
  function automatic logic [2*DW-1:0] alu_calc(input logic [DW-1:0] a,
                                               input logic [DW-1:0] b,
                                               input logic [2:0]    t,
                                               input logic [1:0]    m);
    logic [2*DW-1:0] pr;
    logic [DW-1:0]   f, q;
    pr = '0;
    f  = '0;
    q  = '0;
    case (t)
      3'b100: begin
        pr = a * b;
        f  = pr[DW-1:0];
        q  = pr[2*DW-1:DW];
      end
      3'b010: begin
        if (b != 0) begin
          f = a / b;
          q = a % b;
        end else begin
          f = '1;
        end
      end
      3'b001: begin
        f = a + b + DW'(m);
        q = a - b;
      end
      default: begin
        f = '0;
        q = '0;
      end
    endcase
    return {q, f};
  endfunction

  // expected captured results: illegal type never reaches the ALU and reads 0
  function automatic logic [2*DW-1:0] ref_res(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [2:0]    t,
                                              input logic [1:0]    m);
    if (t == 3'b100 || t == 3'b010 || t == 3'b001) return alu_calc(a, b, t, m);
    return '0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acnt   <= 0;
      m_done <= 1'b0;
      FOUT   <= '0;
      POUT   <= '0;
    end else if (!alu_start) begin
      acnt   <= 0;
      m_done <= 1'b0;
    end else if (!alu_hang && !m_done) begin
      if (acnt >= alu_lat - 1) begin
        m_done       <= 1'b1;
        {POUT, FOUT} <= alu_calc(X_IN, Y_IN, alu_type, mode_type);
      end else begin
        acnt <= acnt + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input int p, input logic [DW-1:0] xa,
                       input logic [DW-1:0] ya, input logic [2:0] ta,
                       input logic [1:0] ma, input int lat,
                       output int st_c, output int ad_c, output int dn_c);
    x[p]    = xa;
    y[p]    = ya;
    typ[p]  = ta;
    mod[p]  = ma;
    alu_lat = lat;
    req[p]  = 1'b1;
    st_c = -1;
    ad_c = -1;
    dn_c = -1;
    for (int n = 1; n <= 200 && dn_c < 0; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) begin
        x[p] = ~xa;
        y[p] = ~ya;
      end
      if (alu_start && st_c < 0) st_c = n;
      if (alu_is_done && ad_c < 0) ad_c = n;
      if (done[p]) dn_c = n;
    end
    if (dn_c < 0) chk("op_done_timeout", 32'(dn_c), 32'(0));
  endtask

  task automatic rel_op(input int p, input string nm);
    int n;
    req[p] = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (!done[p]) break;
    end
    chk({nm, "_rel_cycles"}, 32'(n), 32'(1));
    chk({nm, "_rel_idle"}, 32'(busy), 32'(0));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            p;
    logic [DW-1:0] xv;
    logic [DW-1:0] yv;
    logic [2:0]    t;
    logic [1:0]    m;
    int            lat;
    logic [DW-1:0] ef;
    logic [DW-1:0] ep;
  } vec_t;

  vec_t tbl [10];
  logic [2:0] lg [3];

  initial begin
    int st, ad, dn, w, fall, viol;
    int ph [2];
    int cd [2];
    int wt [2];
    int served [2];
    logic [2*DW-1:0] expv [2];
    bit legal;

    tbl[0] = '{0, 13'h0800, 13'h0400, 3'b100, 2'b00, 20, 13'h0000, 13'h0100};
    tbl[1] = '{1, 13'd3,    13'd5,    3'b100, 2'b01, 3,  13'd15,   13'd0};
    tbl[2] = '{0, 13'h1FFF, 13'h1FFF, 3'b100, 2'b00, 5,  13'h0001, 13'h1FFE};
    tbl[3] = '{1, 13'd100,  13'd7,    3'b010, 2'b00, 7,  13'd14,   13'd2};
    tbl[4] = '{0, 13'd5,    13'd0,    3'b010, 2'b11, 2,  13'h1FFF, 13'd0};
    tbl[5] = '{1, 13'd10,   13'd3,    3'b001, 2'b10, 4,  13'd15,   13'd7};
    tbl[6] = '{0, 13'd0,    13'd1,    3'b001, 2'b01, 1,  13'd2,    13'h1FFF};
    tbl[7] = '{1, 13'd9,    13'd9,    3'b000, 2'b00, 3,  13'd0,    13'd0};
    tbl[8] = '{0, 13'd9,    13'd9,    3'b011, 2'b10, 3,  13'd0,    13'd0};
    tbl[9] = '{1, 13'd9,    13'd9,    3'b111, 2'b01, 3,  13'd0,    13'd0};
    lg[0] = 3'b100;
    lg[1] = 3'b010;
    lg[2] = 3'b001;

    rst_n    = 1'b0;
    req      = '0;
    stale    = 1'b0;
    alu_hang = 1'b0;
    alu_lat  = 4;
    for (int p = 0; p < 2; p++) begin
      x[p]   = '0;
      y[p]   = '0;
      typ[p] = '0;
      mod[p] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_rslt", 32'({rslt_f, rslt_p}), 32'(0));
    chk("rst_busy_err_start", 32'({busy, err, alu_start}), 32'(0));
    chk("rst_alu_ops", 32'({X_IN, Y_IN}), 32'(0));
    chk("rst_type_mode", 32'({alu_type, mode_type}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // vector table (row 0 is the basic multiply, rows 7-9 illegal types)
    foreach (tbl[i]) begin
      legal = (tbl[i].t == 3'b100) || (tbl[i].t == 3'b010) ||
              (tbl[i].t == 3'b001);
      do_op(tbl[i].p, tbl[i].xv, tbl[i].yv, tbl[i].t, tbl[i].m, tbl[i].lat,
            st, ad, dn);
      if (legal) begin
        chk($sformatf("v%0d_start_lat", i), 32'(st), 32'(1));
        chk($sformatf("v%0d_done_lat", i), 32'(dn - ad), 32'(2));
      end else begin
        chk($sformatf("v%0d_no_start", i), 32'(st), 32'(-1));
        chk($sformatf("v%0d_done_lat", i), 32'(dn), 32'(2));
      end
      chk($sformatf("v%0d_rslt_f", i), 32'(rslt_f), 32'(tbl[i].ef));
      chk($sformatf("v%0d_rslt_p", i), 32'(rslt_p), 32'(tbl[i].ep));
      chk($sformatf("v%0d_other_done", i), 32'(done[1-tbl[i].p]), 32'(0));
      rel_op(tbl[i].p, $sformatf("v%0d", i));
    end

    // simultaneous requests after reset, then alternation while both held
    apply_reset();
    x[0] = 13'd3;
    y[0] = 13'd5;
    typ[0] = 3'b100;
    mod[0] = 2'b00;
    x[1] = 13'd100;
    y[1] = 13'd7;
    typ[1] = 3'b010;
    mod[1] = 2'b00;
    alu_lat = 3;
    req = 2'b11;
    for (int k = 0; k < 5; k++) begin
      int who;
      w = 0;
      while (done == 2'b00 && w < 100) begin
        @(posedge clk);
        #1;
        w++;
      end
      chk($sformatf("t2_order%0d", k), 32'(done),
          (k % 2 == 0) ? 32'h1 : 32'h2);
      chk($sformatf("t2_rslt%0d", k), 32'(rslt_f),
          (k % 2 == 0) ? 32'd15 : 32'd14);
      who = done[1] ? 1 : 0;
      rel_op(who, $sformatf("t2_%0d", k));
      if (k < 4) req[who] = 1'b1;
    end
    req = '0;
    @(posedge clk);
    #1;

    // late release keeps REL without reissue
    do_op(1, 13'd100, 13'd7, 3'b010, 2'b00, 4, st, ad, dn);
    w = 0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      if (!busy || !done1 || alu_start) w++;
    end
    chk("t3_hold_rel", 32'(w), 32'(0));
    rel_op(1, "t3");

    // stale alu_is_done while idle must not be taken as completion
    alu_lat = 5;
    x[0] = 13'd7;
    y[0] = 13'd9;
    typ[0] = 3'b100;
    mod[0] = 2'b00;
    stale = 1'b1;
    @(posedge clk);
    #1;
    chk("stale_idle_busy", 32'(busy), 32'(0));
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("stale_no_done", 32'(done0), 32'(0));
    stale = 1'b0;
    w = 0;
    while (!done0 && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("stale_rslt_f", 32'(rslt_f), 32'd63);
    rel_op(0, "stale");

    // reset in the middle of RUN
    alu_lat = 30;
    x[0] = 13'd3;
    y[0] = 13'd5;
    typ[0] = 3'b100;
    req[0] = 1'b1;
    w = 0;
    while (!alu_start && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("t5_started", 32'(alu_start), 32'(1));
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_start_low", 32'(alu_start), 32'(0));
    chk("t5_done_low", 32'(done), 32'(0));
    chk("t5_busy_low", 32'(busy), 32'(0));
    chk("t5_rslt_clr", 32'({rslt_f, rslt_p}), 32'(0));
    req[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(0, 13'd12, 13'd4, 3'b010, 2'b00, 4, st, ad, dn);
    chk("t5_after_start_lat", 32'(st), 32'(1));
    chk("t5_after_rslt", 32'({rslt_f, rslt_p}), 32'({13'd3, 13'd0}));
    rel_op(0, "t5");

`ifdef SUPERALU_TIMEOUT_EN
    alu_hang = 1'b1;
    x[0] = 13'd3;
    y[0] = 13'd5;
    typ[0] = 3'b100;
    req[0] = 1'b1;
    st = -1;
    fall = -1;
    dn = -1;
    for (int n = 1; n <= 100 && dn < 0; n++) begin
      @(posedge clk);
      #1;
      if (alu_start && st < 0) st = n;
      if (!alu_start && st >= 0 && fall < 0) fall = n;
      if (done0) dn = n;
    end
    chk("t6_run_len", 32'(fall - st), 32'(16));
    chk("t6_done_after", 32'(dn - fall), 32'(1));
    chk("t6_err", 32'(err), 32'(1));
    chk("t6_rslt", 32'({rslt_f, rslt_p}), 32'({13'h1FFF, 13'h1FFF}));
    alu_hang = 1'b0;
    rel_op(0, "t6");
    do_op(1, 13'd3, 13'd5, 3'b100, 2'b00, 3, st, ad, dn);
    chk("t6_err_sticky", 32'(err), 32'(1));
    chk("t6_next_rslt", 32'(rslt_f), 32'd15);
    rel_op(1, "t6b");
`endif

    // randomized two-requester traffic
    for (int p = 0; p < 2; p++) begin
      ph[p] = 0;
      cd[p] = p;
      wt[p] = 0;
      served[p] = 0;
      expv[p] = '0;
    end
    viol = 0;
    for (int c = 0; c < 1500; c++) begin
      alu_lat = $urandom_range(1, 6);
      @(posedge clk);
      #1;
      if (done0 && done1) viol++;
      for (int p = 0; p < 2; p++) begin
        case (ph[p])
          0: begin
            if (done[p]) viol++;
            if (cd[p] == 0) begin
              x[p]   = DW'($urandom);
              y[p]   = DW'($urandom);
              mod[p] = 2'($urandom);
              if ($urandom_range(0, 4) == 0) typ[p] = 3'($urandom);
              else typ[p] = lg[$urandom_range(0, 2)];
              expv[p] = ref_res(x[p], y[p], typ[p], mod[p]);
              req[p] = 1'b1;
              wt[p] = 0;
              ph[p] = 1;
            end else begin
              cd[p]--;
            end
          end
          1: begin
            if (done[p]) begin
              chk($sformatf("rand%0d_f", p), 32'(rslt_f),
                  32'(expv[p][DW-1:0]));
              chk($sformatf("rand%0d_p", p), 32'(rslt_p),
                  32'(expv[p][2*DW-1:DW]));
              cd[p] = $urandom_range(0, 3);
              ph[p] = 2;
            end else begin
              wt[p]++;
              if (wt[p] > 200) begin
                chk($sformatf("rand%0d_wait", p), 32'(wt[p]), 32'(0));
                cd[p] = 0;
                ph[p] = 2;
              end
            end
          end
          2: begin
            if (cd[p] == 0) begin
              req[p] = 1'b0;
              wt[p] = 0;
              ph[p] = 3;
            end else begin
              cd[p]--;
            end
          end
          default: begin
            if (!done[p]) begin
              served[p]++;
              cd[p] = $urandom_range(0, 4);
              ph[p] = 0;
            end else begin
              wt[p]++;
              if (wt[p] > 20) begin
                chk($sformatf("rand%0d_release", p), 32'(wt[p]), 32'(0));
                ph[p] = 0;
              end
            end
          end
        endcase
      end
    end
    req = '0;
    w = 0;
    while ((busy || done != 2'b00) && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("rand_drain_idle", 32'(busy), 32'(0));
    chk("rand_invariants", 32'(viol), 32'(0));
    chk("rand_served0", 32'(served[0] > 10), 32'(1));
    chk("rand_served1", 32'(served[1] > 10), 32'(1));
`ifndef SUPERALU_TIMEOUT_EN
    chk("err_tied_low", 32'(err), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
